// File: rtl/gray_step_decoder.sv
// Registered Gray-to-binary decoder with step classification
// (hold / up / down / illegal) and a saturating illegal-step count.
module gray_step_decoder #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             in_valid,
   output logic [WIDTH-1:0] bin_out,
   output logic             out_valid,
   output logic             step_up,
   output logic             step_down,
   output logic             step_hold,
   output logic             step_err,
   output logic             first,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [2:0] {
      STEP_NONE,
      STEP_HOLD,
      STEP_UP,
      STEP_DOWN,
      STEP_ERR
   } step_e;

   // Prefix XOR from the MSB down: each binary bit is the
   // parity of all Gray bits at and above it.
   function automatic logic [WIDTH-1:0] gray2bin(
      input logic [WIDTH-1:0] g
   );
      logic [WIDTH-1:0] b;
      b = '0;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Stage 1 registers
   logic [WIDTH-1:0] s1_gray_q, s1_gray_d;
   logic             s1_valid_q, s1_valid_d;

   // History of the last accepted sample
   logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
   logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
   logic             have_prev_q, have_prev_d;

   // Stage 2 (output) registers
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             out_valid_q, out_valid_d;
   logic             up_q, up_d;
   logic             down_q, down_d;
   logic             hold_q, hold_d;
   logic             err_q, err_d;
   logic             first_q, first_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   // Stage 2 combinational results
   logic [WIDTH-1:0] s1_bin;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] bin_inc;
   logic [WIDTH-1:0] bin_dec;
   logic             diff_zero;
   logic             diff_single;
   step_e            step;

   // Stage 1 capture: data is only loaded on a valid sample,
   // the valid bit itself tracks in_valid every cycle.
   always_comb begin
      s1_valid_d = in_valid;
      s1_gray_d  = s1_gray_q;
      if (in_valid) begin
         s1_gray_d = gray_in;
      end
   end

   // Decode the stage 1 sample and compare against history.
   always_comb begin
      s1_bin      = gray2bin(s1_gray_q);
      diff        = s1_gray_q ^ prev_gray_q;
      bin_inc     = prev_bin_q + WIDTH'(1);
      bin_dec     = prev_bin_q - WIDTH'(1);
      diff_zero   = (diff == '0);
      diff_single = !diff_zero &&
                    ((diff & (diff - WIDTH'(1))) == '0);
   end

   // Classify the step. A single-bit change that is not a
   // +/-1 binary step (e.g. a jump between distant codes)
   // is treated as illegal so exactly one flag is raised.
   always_comb begin
      step = STEP_NONE;
      if (have_prev_q) begin
         unique case (1'b1)
            diff_zero:
               step = STEP_HOLD;
            diff_single && (s1_bin == bin_inc):
               step = STEP_UP;
            diff_single && (s1_bin == bin_dec):
               step = STEP_DOWN;
            default:
               step = STEP_ERR;
         endcase
      end
   end

   // Next-state for outputs and history; everything other
   // than out_valid holds its value through bubbles.
   always_comb begin
      bin_d       = bin_q;
      out_valid_d = 1'b0;
      up_d        = up_q;
      down_d      = down_q;
      hold_d      = hold_q;
      err_d       = err_q;
      first_d     = first_q;
      err_cnt_d   = err_cnt_q;
      prev_gray_d = prev_gray_q;
      prev_bin_d  = prev_bin_q;
      have_prev_d = have_prev_q;
      if (s1_valid_q) begin
         bin_d       = s1_bin;
         out_valid_d = 1'b1;
         up_d        = (step == STEP_UP);
         down_d      = (step == STEP_DOWN);
         hold_d      = (step == STEP_HOLD);
         err_d       = (step == STEP_ERR);
         first_d     = !have_prev_q;
         prev_gray_d = s1_gray_q;
         prev_bin_d  = s1_bin;
         have_prev_d = 1'b1;
         if ((step == STEP_ERR) && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
      end
   end

   // Stage 1 flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_gray_q  <= '0;
         s1_valid_q <= 1'b0;
      end else begin
         s1_gray_q  <= s1_gray_d;
         s1_valid_q <= s1_valid_d;
      end
   end

   // History flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_gray_q <= '0;
         prev_bin_q  <= '0;
         have_prev_q <= 1'b0;
      end else begin
         prev_gray_q <= prev_gray_d;
         prev_bin_q  <= prev_bin_d;
         have_prev_q <= have_prev_d;
      end
   end

   // Output flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q       <= '0;
         out_valid_q <= 1'b0;
         up_q        <= 1'b0;
         down_q      <= 1'b0;
         hold_q      <= 1'b0;
         err_q       <= 1'b0;
         first_q     <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         bin_q       <= bin_d;
         out_valid_q <= out_valid_d;
         up_q        <= up_d;
         down_q      <= down_d;
         hold_q      <= hold_d;
         err_q       <= err_d;
         first_q     <= first_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bin_out   = bin_q;
   assign out_valid = out_valid_q;
   assign step_up   = up_q;
   assign step_down = down_q;
   assign step_hold = hold_q;
   assign step_err  = err_q;
   assign first     = first_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Scoreboard bench for gray_step_decoder: stimulus pushes
// expected results, a negedge monitor pops and compares.
module tb_gray_step_decoder;

   localparam int W = 4;
   localparam int E = 8;
   localparam int N = 1 << W;
   localparam int CMAX = (1 << E) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] gray_in;
   logic         in_valid;
   logic [W-1:0] bin_out;
   logic         out_valid;
   logic         step_up;
   logic         step_down;
   logic         step_hold;
   logic         step_err;
   logic         first;
   logic [E-1:0] err_count;

   gray_step_decoder #(.WIDTH(W), .ERR_W(E)) dut (
      .clk       (clk),
      .rst       (rst),
      .gray_in   (gray_in),
      .in_valid  (in_valid),
      .bin_out   (bin_out),
      .out_valid (out_valid),
      .step_up   (step_up),
      .step_down (step_down),
      .step_hold (step_hold),
      .step_err  (step_err),
      .first     (first),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           t;
      logic [W-1:0] bin;
      logic         up;
      logic         down;
      logic         hold;
      logic         err;
      logic         first;
      logic [E-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // reference model state
   int m_have = 0;
   int m_prev = 0;
   int m_cnt  = 0;

   // inverse of the binary-to-Gray map b ^ (b >> 1)
   function automatic int g2b(input int g);
      for (int b = 0; b < N; b++) begin
         if ((b ^ (b >> 1)) == g) return b;
      end
      return -1;
   endfunction

   function automatic int b2g(input int b);
      int m;
      m = b % N;
      if (m < 0) m += N;
      return m ^ (m >> 1);
   endfunction

   task automatic model_push(input int g);
      exp_t e;
      int   b;
      int   d;
      b = g2b(g);
      e.t = cyc + 2;
      e.bin = W'(b);
      e.up = 0; e.down = 0; e.hold = 0; e.err = 0;
      e.first = (m_have == 0);
      if (m_have != 0) begin
         d = (b - m_prev + N) % N;
         if (d == 0) e.hold = 1;
         else if (d == 1) e.up = 1;
         else if (d == N - 1) e.down = 1;
         else begin
            e.err = 1;
            if (m_cnt < CMAX) m_cnt++;
         end
      end
      e.cnt = E'(m_cnt);
      m_have = 1;
      m_prev = b;
      q.push_back(e);
   endtask

   task automatic send(input int g);
      @(posedge clk);
      #1;
      gray_in  = W'(g);
      in_valid = 1'b1;
      model_push(g);
   endtask

   task automatic bubble(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         gray_in  = W'($urandom_range(N - 1));
      end
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if ({bin_out, out_valid, step_up, step_down, step_hold,
           step_err, first, err_count} !== '0) begin
         errors++;
         $display("FAIL %s: bin=%0d ov=%0b u=%0b d=%0b h=%0b e=%0b f=%0b cnt=%0d required all 0",
                  tag, bin_out, out_valid, step_up, step_down,
                  step_hold, step_err, first, err_count);
      end
   endtask

   // asserts rst off-edge, discards in-flight expectations
   task automatic do_reset(input string tag);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      q.delete();
      m_have = 0;
      m_prev = 0;
      m_cnt  = 0;
      #1;
      check_zero(tag);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) continue;
         if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL extra_out cyc=%0d bin=%0d, none expected",
                        cyc, bin_out);
            end else begin
               e = q.pop_front();
               if (e.t != cyc || bin_out !== e.bin ||
                   step_up !== e.up || step_down !== e.down ||
                   step_hold !== e.hold || step_err !== e.err ||
                   first !== e.first || err_count !== e.cnt) begin
                  errors++;
                  $display("FAIL sample cyc=%0d got bin=%0d u%0b d%0b h%0b e%0b f%0b cnt=%0d, required cyc=%0d bin=%0d u%0b d%0b h%0b e%0b f%0b cnt=%0d",
                     cyc, bin_out, step_up, step_down, step_hold,
                     step_err, first, err_count, e.t, e.bin, e.up,
                     e.down, e.hold, e.err, e.first, e.cnt);
               end
            end
         end else if (q.size() > 0 && q[0].t <= cyc) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL missing_out cyc=%0d out_valid=0, required bin=%0d at cyc=%0d",
                     cyc, e.bin, e.t);
         end
      end
   end

   // stimulus
   initial begin
      int b;
      int r;
      rst      = 1'b1;
      in_valid = 1'b0;
      gray_in  = '0;
      #1;
      check_zero("reset_state");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // full up count 0..15
      for (int i = 0; i < N; i++) send(b2g(i));
      // wrap up, then down across the wrap
      send(0);
      send(b2g(N - 1));
      // hold across a bubble
      send(0);
      bubble(1);
      send(0);
      // illegal step then resync
      send(3);
      send(2);
      bubble(1);
      // saturate the error counter
      for (int i = 0; i < 150; i++) begin
         send(0);
         send(3);
      end
      bubble(3);
      checks++;
      if (err_count !== E'(CMAX)) begin
         errors++;
         $display("FAIL err_sat: err_count=%0d required %0d",
                  err_count, CMAX);
      end

      // reset with samples in flight
      send(b2g(5));
      send(b2g(6));
      do_reset("reset_midstream");
      bubble(2);
      send(b2g(9));
      send(b2g(10));

      // randomized walk with bubbles and jumps
      b = 10;
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(9);
         if (r < 2) begin
            bubble(1);
         end else begin
            if (r < 5) b = b + 1;
            else if (r < 7) b = b - 1;
            else if (r < 9) b = b;
            else b = $urandom_range(N - 1);
            b = ((b % N) + N) % N;
            send(b2g(b));
         end
      end
      bubble(5);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected outputs never seen, required 0",
                  q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
